// File: rtl/ecg_pkg.sv
// Shared types, widths and the gain saturation helper for the ECG LUT player.
package ecg_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 24;
    localparam int PHASE_W = 32;
    localparam int GAIN_W  = 8;
    localparam int PROD_W  = DATA_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0] UNITY_GAIN = {1'b1, {(GAIN_W-1){1'b0}}};

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Drop the unity-gain fraction bits (floor) and clamp to the sample range.
    function automatic logic [DATA_W-1:0] sat_shift(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] v_sh;
        logic [DATA_W-1:0]        v_res;
        v_sh = prod >>> (GAIN_W - 1);
        if (v_sh > SAT_MAX) begin
            v_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v_sh < SAT_MIN) begin
            v_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            v_res = v_sh[DATA_W-1:0];
        end
        return v_res;
    endfunction

endpackage

// File: rtl/ecg_lut_player_if.sv
// Valid/ready sample stream from the LUT player to the DAC/filter chain.
interface ecg_lut_player_if;
    import ecg_pkg::*;

    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              ready;

    modport master (output sample, output valid, input ready);
    modport slave  (input sample, input valid, output ready);

endinterface

// File: rtl/ecg_gain_sat.sv
// Output stage: signed sample times unsigned gain, rescaled and saturated, held while stalled.
module ecg_gain_sat
    import ecg_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [GAIN_W-1:0] i_gain,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_sample
);

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] w_prod;

    // The gain gets a zero sign bit so it is always treated as positive.
    assign w_a    = {{(PROD_W-DATA_W){i_sample[DATA_W-1]}}, i_sample};
    assign w_b    = {{(PROD_W-GAIN_W){1'b0}}, i_gain};
    assign w_prod = w_a * w_b;

    // Output register, advancing only when the stream can move.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_sample <= {DATA_W{1'b0}};
        end else if (i_en) begin
            o_valid  <= i_valid;
            o_sample <= sat_shift(w_prod);
        end
    end

endmodule

// File: rtl/ecg_lut_player.sv
// Phase-accumulator reader of the ECG waveform LUT with gain stage and valid/ready output.
module ecg_lut_player
    import ecg_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_one_shot,
    input  logic [PHASE_W-1:0] i_ftw,
    input  logic [GAIN_W-1:0]  i_gain,
    output logic [ADDR_W-1:0]  o_lut_addr,
    input  logic [DATA_W-1:0]  i_lut_data,
    output logic               o_busy,
    output logic               o_wrap,
    ecg_lut_player_if.master   stream
);

    state_t             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_ftw;
    logic [GAIN_W-1:0]  r_gain;
    logic               r_one_shot;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_s0_valid;
    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_data;
    logic               r_busy;
    logic               r_wrap;

    logic               w_adv;
    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic               w_last;
    logic               w_empty;
    logic               w_s2_valid;
    logic [DATA_W-1:0]  w_s2_sample;

    assign w_adv   = !w_s2_valid || stream.ready;
    assign w_sum   = {1'b0, r_phase} + {1'b0, r_ftw};
    assign w_carry = w_sum[PHASE_W];
    // A zero step never carries, so one-shot would otherwise never end.
    assign w_last  = r_one_shot && (w_carry || (r_ftw == {PHASE_W{1'b0}}));
    assign w_empty = !r_s0_valid && !r_s1_valid && !w_s2_valid;

    // Control FSM, phase accumulator and S0 address stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_phase    <= {PHASE_W{1'b0}};
            r_ftw      <= {PHASE_W{1'b0}};
            r_gain     <= UNITY_GAIN;
            r_one_shot <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_s0_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        r_ftw      <= i_ftw;
                        r_gain     <= i_gain;
                        r_one_shot <= i_one_shot;
                        r_phase    <= {PHASE_W{1'b0}};
                        r_addr     <= {ADDR_W{1'b0}};
                        r_s0_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_adv) begin
                        if (i_stop) begin
                            r_s0_valid <= 1'b0;
                            r_state    <= DRAIN;
                        end else if (w_last) begin
                            r_phase    <= w_sum[PHASE_W-1:0];
                            r_wrap     <= w_carry;
                            r_s0_valid <= 1'b0;
                            r_state    <= DRAIN;
                        end else begin
                            r_phase    <= w_sum[PHASE_W-1:0];
                            r_addr     <= w_sum[PHASE_W-1 -: ADDR_W];
                            r_wrap     <= w_carry;
                            r_s0_valid <= 1'b1;
                        end
                    end else if (i_stop) begin
                        // Stalled: keep the S0 sample, it drains once the stream moves.
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_adv) begin
                        r_s0_valid <= 1'b0;
                    end
                    if (w_empty) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_s0_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // S1: capture the combinational LUT read for the issued address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DATA_W{1'b0}};
        end else if (w_adv) begin
            r_s1_valid <= r_s0_valid;
            r_s1_data  <= i_lut_data;
        end
    end

    ecg_gain_sat u_gain_sat (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_adv),
        .i_valid  (r_s1_valid),
        .i_sample (r_s1_data),
        .i_gain   (r_gain),
        .o_valid  (w_s2_valid),
        .o_sample (w_s2_sample)
    );

    assign stream.valid  = w_s2_valid;
    assign stream.sample = w_s2_sample;
    assign o_lut_addr    = r_addr;
    assign o_busy        = r_busy;
    assign o_wrap        = r_wrap;

endmodule
